// File: rtl/nios_128k_base_pkg.sv
// Shared platform constants for the base key PIO: register map and debounce sizing.
package nios_128k_base_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Counter must hold 0..cycles-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/nios_128k_base_key_debounce.sv
// One key bit: 2-flop synchronizer followed by a stable-run debounce counter.
module nios_128k_base_key_debounce
  import nios_128k_base_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_i,
  output logic key_db_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // A return to the debounced level discards any partial count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign key_db_o = db_q;

endmodule

// File: rtl/nios_128k_base_key_pio.sv
// Avalon-MM key PIO: debounced active-low keys, press-edge capture with W1C, masked level irq.
module nios_128k_base_key_pio
  import nios_128k_base_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wr_clr;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    nios_128k_base_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .key_i   (in_port[i]),
      .key_db_o(db[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // db_prev resets to all-ones so reset release never looks like a press.
  assign fall   = db_prev_q & ~db;
  assign wr_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    // New edges are OR-ed after the clear, so a colliding edge wins.
    edge_d = (edge_q & ~wr_clr) | fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_q <= '1;
      mask_q    <= '0;
      edge_q    <= '0;
    end else begin
      db_prev_q <= db;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = db;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_128k_base_key_pio.sv
// Bench for the key PIO: directed scenarios with literal reads plus random traffic
// checked every cycle against a run-length behavioural model.
module tb_nios_128k_base_key_pio;

  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  nios_128k_base_key_pio #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each key is a delay line of two samples; the debounced level flips once DC
  // consecutive delayed samples disagree with it. A press is logged one cycle later.
  typedef struct {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] db;
    logic [W-1:0] fall;
    logic [W-1:0] mask;
    logic [W-1:0] edge_c;
    int           run [W];
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.s1 = '1; r.s2 = '1; r.db = '1; r.fall = '0; r.mask = '0; r.edge_c = '0;
    for (int i = 0; i < W; i++) r.run[i] = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic [W-1:0] pin, logic wr,
                                        logic [1:0] a, logic [31:0] wd);
    model_t n;
    logic [W-1:0] sample;
    n = c;
    n.edge_c = (c.edge_c & ~((wr && a == 2'd3) ? wd[W-1:0] : '0)) | c.fall;
    if (wr && a == 2'd1) n.mask = wd[W-1:0];
    sample = c.s2;
    n.s2 = c.s1;
    n.s1 = pin;
    for (int i = 0; i < W; i++) begin
      if (sample[i] != c.db[i]) begin
        n.run[i] = c.run[i] + 1;
        if (n.run[i] == DC) begin
          n.db[i]  = sample[i];
          n.run[i] = 0;
        end
      end else begin
        n.run[i] = 0;
      end
    end
    n.fall = c.db & ~n.db;
    return n;
  endfunction

  function automatic logic [31:0] model_read(model_t c, logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0: r[W-1:0] = c.db;
      2'd1: r[W-1:0] = c.mask;
      2'd3: r[W-1:0] = c.edge_c;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else m <= model_step(m, in_port, chipselect & ~write_n, address, writedata);
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_q.push_back({irq_exp(m), model_read(m, address)});
      begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("model_readdata", readdata, e[31:0]);
        check("model_irq", {31'd0, irq}, {31'd0, e[32]});
      end
    end
  end

  function automatic logic irq_exp(model_t c);
    return |(c.edge_c & c.mask);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_in(input logic [W-1:0] v);
    @(posedge clk); #1;
    in_port = v;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    @(negedge clk);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset_n = 1'b0;
    idle(3); #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Reset values
    rd(2'd0, 32'h0000_000F, "reset_data");
    rd(2'd1, 32'h0, "reset_mask");
    rd(2'd3, 32'h0, "reset_edge");
    rd(2'd2, 32'h0, "reset_rsvd");
    chk_irq(1'b0, "reset_irq");

    // Single press on bit0
    set_in(4'hE);
    idle(10);
    rd(2'd0, 32'h0000_000E, "press_data");
    rd(2'd3, 32'h1, "press_edge");
    chk_irq(1'b0, "press_irq_masked");
    wr(2'd1, 32'h1);
    chk_irq(1'b1, "press_irq_unmasked");
    wr(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, 32'h0000_000E, "data_write_ignored");

    // Release, clear, then a 3-cycle glitch on bit2
    set_in(4'hF);
    idle(10);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "edge_cleared");
    set_in(4'hB);
    idle(2);
    set_in(4'hF);
    idle(10);
    rd(2'd0, 32'h0000_000F, "glitch_data");
    rd(2'd3, 32'h0, "glitch_edge");

    // Two presses then selective clears
    set_in(4'hA);
    idle(10);
    set_in(4'hF);
    idle(10);
    wr(2'd1, 32'h4);
    rd(2'd3, 32'h5, "clr_edge_before");
    chk_irq(1'b1, "clr_irq_before");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h1, "clr_edge_bit2");
    chk_irq(1'b0, "clr_irq_after");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "clr_edge_bit0");

    // Clear landing on the very cycle bit1's edge is captured
    wr(2'd1, 32'h2);
    set_in(4'hD);
    idle(6); #1;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    rd(2'd3, 32'h2, "collision_edge");
    chk_irq(1'b1, "collision_irq");
    set_in(4'hF);
    idle(10);

    // Reset while bit3's counter is part way through
    set_in(4'h7);
    idle(4); #1;
    reset_n = 1'b0;
    idle(2); #1;
    reset_n = 1'b1;
    rd(2'd0, 32'h0000_000F, "midrst_data");
    rd(2'd1, 32'h0, "midrst_mask");
    rd(2'd3, 32'h0, "midrst_edge");
    chk_irq(1'b0, "midrst_irq");
    idle(10);
    rd(2'd0, 32'h0000_0007, "midrst_repress_data");
    rd(2'd3, 32'h8, "midrst_repress_edge");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) in_port = W'($urandom_range(0, (1 << W) - 1));
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
    end
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_128k_base_key_pio.md
NIOS_128K_BASE_KEY_PIO -- requirements
Module: nios_128k_base_key_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of key inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the stable-cycle count required before a debounced bit changes (>=1).
REQ-003 SHALL have port clk, input, 1 bit, the system clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port address, input, 2 bits, the Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1 bit, the slave select.
REQ-007 SHALL have port write_n, input, 1 bit, the write strobe (active-low).
REQ-008 SHALL have port writedata, input, 32 bits, the write data.
REQ-009 SHALL have port in_port, input, WIDTH bits, the raw asynchronous key levels (active-low, pressed = 0).
REQ-010 SHALL have port readdata, output, 32 bits, the read data.
REQ-011 SHALL have port irq, output, 1 bit, the level interrupt request (active-high).

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep a per-bit debounce counter: cleared when the synced bit equals the debounced bit, incremented otherwise.
REQ-014 SHALL load the synced value into the debounced bit, and clear that bit's counter, on the cycle its counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present.
REQ-015 SHALL restart the count from 0 whenever a glitch returns to the debounced level before the count completes; no partial count SHALL be retained.
REQ-016 SHALL detect a falling edge on a debounced bit (1 -> 0, a press) and set the matching edge_capture bit one cycle after the debounced bit changes.
REQ-017 SHALL decode registers as follows (bits above WIDTH SHALL read 0):
- addr 0: debounced data, read-only; writes ignored.
- addr 1: irq_mask, read/write.
- addr 2: reserved, reads 0; writes ignored.
- addr 3: edge_capture, read; a write with bit=1 clears that bit, bit=0 leaves it unchanged.
REQ-018 SHALL perform writes only when chipselect=1 and write_n=0, taking effect on the next clk edge.
REQ-019 SHALL drive readdata combinationally from address and register state, with zero wait states and zero read latency; reads SHALL have no side effects.
REQ-020 SHALL, when a write-1-to-clear and a new edge hit the same edge_capture bit in the same cycle, let the edge win and leave the bit at 1.
REQ-021 SHALL drive irq = OR-reduction of (edge_capture AND irq_mask), combinational from registers.
REQ-022 SHALL, when irq_mask is changed, let irq follow immediately without clearing edge_capture.

Reset
REQ-023 SHALL, while reset_n=0, set synchronizer flops and debounced bits to all-ones, and set debounce counters, edge_capture and irq_mask to 0.
REQ-024 SHALL hold irq=0 and readdata at addr 0 equal to all-ones (within WIDTH) immediately after reset.
REQ-025 SHALL detect no edge on the first cycles after reset release unless in_port actually goes low and completes debouncing.

Structure
REQ-026 SHALL place the register address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=3) in the shared platform package nios_128k_base_pkg.
REQ-027 SHALL implement one per-bit sub-module, nios_128k_base_key_debounce (synchronizer, counter, debounced output), instantiated WIDTH times.
REQ-028 SHALL size the counter width as clog2(DEBOUNCE_CYCLES), computed from the parameter and not hard-coded.

Verification (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-029 SHALL check reset: after reset release, read addr 0 -> 0x0000000F; addr 1 -> 0; addr 3 -> 0; irq=0.
REQ-030 SHALL check a press: in_port 0xF -> 0xE held for 10 cycles -> addr 0 reads 0xE, addr 3 reads 0x1; irq stays 0 with mask 0; write 0x1 to addr 1 -> irq=1.
REQ-031 SHALL check glitch rejection: in_port bit2 low for 3 cycles then high -> addr 0 stays 0xF, edge_capture stays 0.
REQ-032 SHALL check clear: with edge_capture=0x5 and mask=0x4, write 0x4 to addr 3 -> edge_capture 0x1, irq=0; write 0x1 -> edge_capture 0x0.
REQ-033 SHALL check the collision: a write of 0x2 to addr 3 in the same cycle bit1's edge sets -> edge_capture bit1 reads 1.
REQ-034 SHALL check reset mid-debounce: reset_n pulsed low while a counter is at 2 -> all state returns to REQ-023 values and the press is counted again from 0.
